// File: rtl/turn_controller.sv
// Turn sequencer for an N-player Connect4 game: retries with forfeit, per-turn
// move timeout, and sticky win/tie results held until reset or new_game.
module turn_controller #(
    parameter int unsigned  NUM_PLAYERS    = 2,
    parameter int unsigned  TIMEOUT_CYCLES = 1000,
    parameter int unsigned  MAX_RETRIES    = 3,
    localparam int unsigned PW             = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int unsigned RW             = $clog2(MAX_RETRIES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          new_game,
    input  logic          move_valid,
    input  logic          invalid_column,
    input  logic [1:0]    in_game_status,
    output logic [1:0]    current_state,
    output logic [PW-1:0] current_player,
    output logic [PW-1:0] winner,
    output logic [1:0]    out_game_status,
    output logic          throw_again,
    output logic          turn_skipped,
    output logic [RW-1:0] retry_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_TURN  = 2'b00,
        S_CHECK = 2'b01,
        S_WIN   = 2'b10,
        S_TIE   = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_player, w_player_nxt;
    logic [PW-1:0]   r_winner, w_winner_nxt;
    logic [1:0]      r_status, w_status_nxt;
    logic            r_throw,  w_throw_nxt;
    logic            r_skip,   w_skip_nxt;
    logic [RW-1:0]   r_retry,  w_retry_nxt;
    logic [TW-1:0]   r_timer,  w_timer_nxt;

    logic            w_valid_move;
    logic            w_invalid_move;
    logic            w_timer_exp;
    logic            w_retry_lim;
    logic [PW-1:0]   w_player_adv;

    assign w_valid_move   = move_valid & ~invalid_column;
    assign w_invalid_move = move_valid &  invalid_column;
    assign w_timer_exp    = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_retry_lim    = (r_retry >= RW'(MAX_RETRIES - 1));
    // Explicit wrap so non-power-of-2 player counts return to 0
    assign w_player_adv   = (r_player == PW'(NUM_PLAYERS - 1)) ? '0 : r_player + PW'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_TURN;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (new_game) begin
            w_state_nxt = S_TURN;
        end else begin
            case (r_state)
                S_TURN:  if (w_valid_move) w_state_nxt = S_CHECK;
                S_CHECK: begin
                    case (in_game_status)
                        2'b01:   w_state_nxt = S_WIN;
                        2'b10:   w_state_nxt = S_TIE;
                        default: w_state_nxt = S_TURN;
                    endcase
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Next values of the registered outputs, timer and retry counter
    always_comb begin
        w_player_nxt = r_player;
        w_winner_nxt = r_winner;
        w_status_nxt = r_status;
        w_throw_nxt  = 1'b0;
        w_skip_nxt   = 1'b0;
        w_retry_nxt  = r_retry;
        w_timer_nxt  = r_timer;
        if (new_game) begin
            w_player_nxt = '0;
            w_winner_nxt = '0;
            w_status_nxt = 2'b00;
            w_retry_nxt  = '0;
            w_timer_nxt  = '0;
        end else begin
            case (r_state)
                S_TURN: begin
                    if (w_valid_move) begin
                        w_retry_nxt = '0;
                        w_timer_nxt = '0;
                    end else if (w_invalid_move) begin
                        w_timer_nxt = '0;
                        if (!w_retry_lim) begin
                            w_retry_nxt = r_retry + RW'(1);
                            w_throw_nxt = 1'b1;
                        end else begin
                            w_player_nxt = w_player_adv;
                            w_skip_nxt   = 1'b1;
                            w_retry_nxt  = '0;
                        end
                    end else if (w_timer_exp) begin
                        w_player_nxt = w_player_adv;
                        w_skip_nxt   = 1'b1;
                        w_retry_nxt  = '0;
                        w_timer_nxt  = '0;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                S_CHECK: begin
                    w_timer_nxt = '0;
                    case (in_game_status)
                        2'b01: begin
                            w_winner_nxt = r_player;
                            w_status_nxt = 2'b01;
                        end
                        2'b10:   w_status_nxt = 2'b10;
                        default: w_player_nxt = w_player_adv;
                    endcase
                end
                default: w_timer_nxt = '0;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_player <= '0;
            r_winner <= '0;
            r_status <= 2'b00;
            r_throw  <= 1'b0;
            r_skip   <= 1'b0;
            r_retry  <= '0;
            r_timer  <= '0;
        end else begin
            r_player <= w_player_nxt;
            r_winner <= w_winner_nxt;
            r_status <= w_status_nxt;
            r_throw  <= w_throw_nxt;
            r_skip   <= w_skip_nxt;
            r_retry  <= w_retry_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    assign current_state   = r_state;
    assign current_player  = r_player;
    assign winner          = r_winner;
    assign out_game_status = r_status;
    assign throw_again     = r_throw;
    assign turn_skipped    = r_skip;
    assign retry_count     = r_retry;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: a 2-player and a 3-player instance share directed
// stimulus and are compared every cycle against a turn-level reference model.
module tb_turn_controller;

    localparam int TO = 8;
    localparam int MR = 3;

    logic       clk;
    logic       reset;
    logic       new_game;
    logic       move_valid;
    logic       invalid_column;
    logic [1:0] in_game_status;

    logic [1:0] a_state, b_state;
    logic       a_player, a_winner;
    logic [1:0] b_player, b_winner;
    logic [1:0] a_status, b_status;
    logic       a_throw, b_throw, a_skip, b_skip;
    logic [1:0] a_retry, b_retry;

    int checks;
    int failures;

    turn_controller #(.NUM_PLAYERS(2), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) u_a (
        .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
        .invalid_column(invalid_column), .in_game_status(in_game_status),
        .current_state(a_state), .current_player(a_player), .winner(a_winner),
        .out_game_status(a_status), .throw_again(a_throw), .turn_skipped(a_skip),
        .retry_count(a_retry)
    );

    turn_controller #(.NUM_PLAYERS(3), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) u_b (
        .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
        .invalid_column(invalid_column), .in_game_status(in_game_status),
        .current_state(b_state), .current_player(b_player), .winner(b_winner),
        .out_game_status(b_status), .throw_again(b_throw), .turn_skipped(b_skip),
        .retry_count(b_retry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Turn-level game model: age counts cycles spent in the current turn
    typedef struct packed {
        int st; int pl; int wn; int gs; int thr; int skp; int rty; int age;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t nxt(input mdl_t m, input int np, input logic mv,
                                 input logic inv, input logic ng, input logic [1:0] res);
        mdl_t r;
        r     = m;
        r.thr = 0;
        r.skp = 0;
        if (ng) return '0;
        if (m.st == 0) begin
            if (mv && !inv) begin
                r.st = 1; r.age = 0; r.rty = 0;
            end else if (mv) begin
                r.age = 0;
                if (m.rty + 1 < MR) begin
                    r.rty = m.rty + 1; r.thr = 1;
                end else begin
                    r.pl = (m.pl + 1) % np; r.skp = 1; r.rty = 0;
                end
            end else begin
                r.age = m.age + 1;
                if (r.age == TO) begin
                    r.pl = (m.pl + 1) % np; r.skp = 1; r.age = 0; r.rty = 0;
                end
            end
        end else if (m.st == 1) begin
            if (res == 2'b01) begin
                r.st = 2; r.wn = m.pl; r.gs = 1;
            end else if (res == 2'b10) begin
                r.st = 3; r.gs = 2;
            end else begin
                r.st = 0; r.pl = (m.pl + 1) % np;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= nxt(ma, 2, move_valid, invalid_column, new_game, in_game_status);
            mb <= nxt(mb, 3, move_valid, invalid_column, new_game, in_game_status);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a_state",  int'(a_state),  ma.st);
        chk("a_player", int'(a_player), ma.pl);
        chk("a_winner", int'(a_winner), ma.wn);
        chk("a_status", int'(a_status), ma.gs);
        chk("a_throw",  int'(a_throw),  ma.thr);
        chk("a_skip",   int'(a_skip),   ma.skp);
        chk("a_retry",  int'(a_retry),  ma.rty);
        chk("b_state",  int'(b_state),  mb.st);
        chk("b_player", int'(b_player), mb.pl);
        chk("b_winner", int'(b_winner), mb.wn);
        chk("b_status", int'(b_status), mb.gs);
        chk("b_throw",  int'(b_throw),  mb.thr);
        chk("b_skip",   int'(b_skip),   mb.skp);
        chk("b_retry",  int'(b_retry),  mb.rty);
    endtask

    // Drive at the falling edge, let one rising edge act, compare at the next falling edge
    task automatic step(input logic mv, input logic inv, input logic [1:0] res, input logic ng);
        move_valid     = mv;
        invalid_column = inv;
        in_game_status = res;
        new_game       = ng;
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        new_game       = 1'b0;
        move_valid     = 1'b0;
        invalid_column = 1'b0;
        in_game_status = 2'b00;
        #1 reset = 1'b0;
        @(negedge clk);
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        compare_all();
        chk("lit_reset_state", int'(a_state), 0);
        chk("lit_reset_player", int'(b_player), 0);

        // Move, continue, then win for player 1
        step(1'b1, 1'b0, 2'b00, 1'b0);
        chk("lit_check_state", int'(a_state), 1);
        step(1'b0, 1'b0, 2'b00, 1'b0);
        chk("lit_a_player1", int'(a_player), 1);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 2'b01, 1'b0);
        chk("lit_win_state", int'(a_state), 2);
        chk("lit_win_winner", int'(a_winner), 1);
        chk("lit_win_status", int'(a_status), 1);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b1, 2'b10, 1'b0);
        idle(3);
        chk("lit_win_sticky", int'(a_state), 2);

        // new_game from WIN
        step(1'b0, 1'b0, 2'b00, 1'b1);
        chk("lit_ng_state", int'(a_state), 0);
        chk("lit_ng_winner", int'(a_winner), 0);

        // Retry forfeit
        step(1'b1, 1'b1, 2'b00, 1'b0);
        chk("lit_throw1", int'(b_throw), 1);
        chk("lit_retry1", int'(b_retry), 1);
        step(1'b1, 1'b1, 2'b00, 1'b0);
        chk("lit_retry2", int'(b_retry), 2);
        step(1'b1, 1'b1, 2'b00, 1'b0);
        chk("lit_forfeit_skip", int'(b_skip), 1);
        chk("lit_forfeit_throw", int'(b_throw), 0);
        chk("lit_forfeit_player", int'(b_player), 1);
        chk("lit_forfeit_retry", int'(b_retry), 0);
        idle(1);

        // Timeout
        step(1'b0, 1'b0, 2'b00, 1'b1);
        idle(7);
        chk("lit_to_pre", int'(b_skip), 0);
        idle(1);
        chk("lit_to_skip", int'(b_skip), 1);
        chk("lit_to_player", int'(b_player), 1);
        idle(16);
        chk("lit_to_wrap", int'(b_player), 0);
        idle(7);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        chk("lit_move_at_expiry", int'(b_state), 1);
        chk("lit_move_no_skip", int'(b_skip), 0);
        step(1'b0, 1'b0, 2'b00, 1'b0);

        // Invalid move restarts the turn timer
        step(1'b0, 1'b0, 2'b00, 1'b1);
        idle(5);
        step(1'b1, 1'b1, 2'b00, 1'b0);
        idle(7);
        chk("lit_retry_timer_hold", int'(b_skip), 0);
        idle(1);
        chk("lit_retry_timer_skip", int'(b_skip), 1);
        chk("lit_retry_timer_rc", int'(b_retry), 0);

        // Wraparound and tie; move_valid during CHECK is ignored
        step(1'b0, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'b00, 1'b0);
            step(1'b1, 1'b0, 2'b11, 1'b0);
        end
        chk("lit_wrap_player", int'(b_player), 0);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 2'b10, 1'b0);
        chk("lit_tie_state", int'(b_state), 3);
        chk("lit_tie_status", int'(b_status), 2);
        chk("lit_tie_player", int'(b_player), 0);
        idle(TO + 2);

        // Asynchronous reset while in CHECK
        step(1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b1, 1'b1, 2'b00, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0);
        chk("lit_pre_rst_check", int'(b_state), 1);
        move_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        compare_all();
        chk("lit_arst_state", int'(b_state), 0);
        chk("lit_arst_retry", int'(a_retry), 0);
        @(negedge clk);
        reset = 1'b1;
        compare_all();
        idle(TO + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/turn_controller.md
# turn_controller

Parametrised successor to the two-player game FSM for the Connect4 design. It sequences turns among `NUM_PLAYERS` players, tracks invalid-column retries with a forfeit limit, and skips a player whose move timer expires. It latches win/tie results until restart. It sits between the column-input/drop logic (which supplies `move_valid` and `invalid_column`) and the board checker (which supplies `in_game_status`), and drives the display and turn indicator.

## Interface
- `NUM_PLAYERS`, 2: number of players, legal range 2..4; `PW` = max(1, clog2(`NUM_PLAYERS`)).
- `TIMEOUT_CYCLES`, 1000: cycles allowed per turn before the player is skipped; must be ≥2.
- `MAX_RETRIES`, 3: invalid-column attempts allowed per turn before forfeit; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `new_game` in 1: synchronous restart, same effect as reset; priority over all other inputs.
- `move_valid` in 1: one-cycle strobe; the current player attempted a drop.
- `invalid_column` in 1: qualifies `move_valid`; the selected column is full or out of range.
- `in_game_status` in 2: board checker result, sampled only in CHECK. 00 = continue, 01 = current player won, 10 = tie, 11 = treated as 00.
- `current_state` out 2: 00 TURN, 01 CHECK, 10 WIN, 11 TIE.
- `current_player` out PW: index of the player to move.
- `winner` out PW: index of the winning player; valid only in WIN.
- `out_game_status` out 2: 00 in play, 01 win, 10 tie.
- `throw_again` out 1: one-cycle pulse; the invalid attempt is rejected and the same player retries.
- `turn_skipped` out 1: one-cycle pulse; the turn was lost to timeout or retry forfeit.
- `retry_count` out clog2(`MAX_RETRIES`+1): invalid attempts so far in the current turn.

## Operation
- Reset or `new_game` sets all outputs to 0: state TURN, player 0, winner 0, status 00, pulses 0, retry and timer 0.
- Priority within TURN, highest first: `new_game`, then a valid move, then an invalid move, then timeout.
- **TURN, valid move** (`move_valid`=1, `invalid_column`=0): go to CHECK; timer and retry clear.
- **TURN, invalid move** (`move_valid`=1, `invalid_column`=1):
  - If `retry_count` < `MAX_RETRIES`-1: `retry_count` increments, `throw_again` pulses, state stays TURN, timer restarts at 0.
  - Otherwise (forfeit): advance player, `turn_skipped` pulses, retry and timer clear. `throw_again` does not pulse.
- **TURN, no move**: timer increments each cycle.
  - When the timer equals `TIMEOUT_CYCLES`-1 and there is no move that cycle: advance player, `turn_skipped` pulses, timer and retry clear.
  - A move arriving on the expiry cycle takes precedence over the timeout.
- **CHECK** lasts exactly 1 cycle:
  - `in_game_status` 01: go to WIN; `winner` gets `current_player`; `out_game_status` = 01.
  - 10: go to TIE; `out_game_status` = 10.
  - 00 or 11: advance player, return to TURN.
- **Advance player**: `current_player` becomes (`current_player`+1) mod `NUM_PLAYERS`. It wraps from `NUM_PLAYERS`-1 to 0 even when `NUM_PLAYERS` is not a power of 2.
- **WIN and TIE** are sticky. `move_valid`, `invalid_column`, `in_game_status` and the timer are ignored; the timer is held at 0. Only `reset` or `new_game` exits.
- `move_valid` in CHECK, WIN or TIE is ignored.
- `current_player` does not change in WIN or TIE.

## Timing
- All outputs are registered. The response appears on the rising edge after the input is sampled.
- Valid move at edge N: state is CHECK after edge N; `in_game_status` is sampled at edge N+1; the result state or next player is visible after edge N+1.
- `throw_again` and `turn_skipped` are high for exactly one cycle, the cycle after the triggering edge, and are never high together.
- Timeout: with no moves from turn start, the skip occurs `TIMEOUT_CYCLES` cycles after entering TURN.
- Asserting `reset` forces all outputs to 0 immediately, independent of `clk`, including mid-CHECK and during a pulse.
- Deassertion of `reset` is synchronised externally; the first active edge after release behaves as TURN.
- `new_game` takes effect at the next edge.

## Test plan
- **Reset and win**, `NUM_PLAYERS`=2, held in reset then released: all outputs 0.
  - Valid move, then `in_game_status`=00: `current_player`=1.
  - Valid move, then 01: state=10, `winner`=1, `out_game_status`=01.
  - Further moves leave outputs unchanged.
- **Retry forfeit**, `MAX_RETRIES`=3:
  - Two invalid moves: two `throw_again` pulses, `retry_count` 1 then 2, player unchanged.
  - Third invalid move: `turn_skipped` pulses, `current_player` advances, `retry_count`=0.
- **Timeout**, `TIMEOUT_CYCLES`=8, `NUM_PLAYERS`=3:
  - Idle 8 cycles: player 0→1 with a `turn_skipped` pulse.
  - Idle 16 more cycles: player 1→2→0.
  - Valid move on cycle 7 of a turn: CHECK entered, no skip.
- **Wraparound and tie**, `NUM_PLAYERS`=3: three valid moves with status 00 give player sequence 0,1,2,0. Status 10 in CHECK: state=11, `out_game_status`=10, `current_player` held.
- **Asynchronous reset**: assert `reset` between clock edges while in CHECK; all outputs go to 0 before the next edge.
- **`new_game` from WIN**: returns to TURN with player 0, timer 0, retry 0.
